// File: rtl/mem_burst_responder.sv
// -----------------------------------------------------------------------------
// mem_burst_responder
//
// Purpose:
//   Behavioural memory that answers cache-line read requests with fixed
//   8-beat (8 x 32-bit = 32-byte) bursts. A request captures the line number;
//   beats always start at word 0 of the line and step one word per accepted
//   beat. The backing store is loaded through a separate preload write port
//   that works in every state, including during an active burst.
//
// Configuration:
//   `define MEM_BURST_DELAY_EN  -- inserts a DELAY state between acceptance and
//                                  the first beat, lasting DELAY_CYCLES cycles.
//                                  Without it there is no DELAY state or delay
//                                  counter, and DELAY_CYCLES has no effect.
//
// Parameters:
//   MEM_AW        word-address width of the memory (2**MEM_AW 32-bit words)
//   DELAY_CYCLES  first-beat delay when MEM_BURST_DELAY_EN is defined
//
// Ports:
//   clk                      single clock, rising edge
//   rst                      asynchronous, active-high reset
//   from_cache_rd_req_valid  read request valid
//   from_cache_rd_req_addr   request byte address (bits [4:0] ignored)
//   to_cache_rd_req_ready    high only in IDLE
//   to_cache_rd_rsp_valid    high exactly while in BURST
//   to_cache_rd_rsp_data     current beat, read combinationally from memory
//   to_cache_rd_rsp_last     current beat is the 8th of the burst
//   from_cache_rd_rsp_ready  requester accepts current beat
//   init_wen/waddr/wdata     preload write port
// -----------------------------------------------------------------------------
module mem_burst_responder #(
    parameter int MEM_AW       = 10,
    parameter int DELAY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              from_cache_rd_req_valid,
    input  logic [31:0]       from_cache_rd_req_addr,
    output logic              to_cache_rd_req_ready,
    output logic              to_cache_rd_rsp_valid,
    output logic [31:0]       to_cache_rd_rsp_data,
    output logic              to_cache_rd_rsp_last,
    input  logic              from_cache_rd_rsp_ready,
    input  logic              init_wen,
    input  logic [MEM_AW-1:0] init_waddr,
    input  logic [31:0]       init_wdata
);

    // Only the line bits that land inside the memory are kept, so addresses
    // beyond the memory size wrap naturally.
    localparam int LINE_W = MEM_AW - 3;

`ifdef MEM_BURST_DELAY_EN
    typedef enum logic [1:0] {IDLE, DELAY, BURST} state_t;

    localparam int               DLY_W    = (DELAY_CYCLES > 0) ? $clog2(DELAY_CYCLES + 1) : 1;
    localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY_CYCLES);

    logic [DLY_W-1:0] dly_q, dly_d;
`else
    typedef enum logic {IDLE, BURST} state_t;
`endif

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [MEM_AW-1:0] beat_addr;

    logic [31:0] mem [0:(2**MEM_AW)-1];

    // Address bits that are intentionally not used: the byte offset within the
    // line and everything above the memory size.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{from_cache_rd_req_addr[31:MEM_AW+2],
                                from_cache_rd_req_addr[4:0]};
`ifndef MEM_BURST_DELAY_EN
    logic unused_delay_cfg;
    assign unused_delay_cfg = (DELAY_CYCLES != 0);
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
`ifdef MEM_BURST_DELAY_EN
            dly_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
`ifdef MEM_BURST_DELAY_EN
            dly_q   <= dly_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Memory: preload write port plus combinational beat read
    // -------------------------------------------------------------------------
    // NOTE: the storage array is deliberately left out of reset; its contents
    // survive rst and only the preload port changes them.
    always_ff @(posedge clk) begin
        if (init_wen) begin
            mem[init_waddr] <= init_wdata;
        end
    end

    assign beat_addr            = {line_q, cnt_q};
    assign to_cache_rd_rsp_data = mem[beat_addr];

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d               = state_q;
        cnt_d                 = cnt_q;
        line_d                = line_q;
`ifdef MEM_BURST_DELAY_EN
        dly_d                 = dly_q;
`endif
        to_cache_rd_req_ready = 1'b0;
        to_cache_rd_rsp_valid = 1'b0;
        to_cache_rd_rsp_last  = 1'b0;

        unique case (state_q)
            IDLE: begin
                to_cache_rd_req_ready = 1'b1;
                if (from_cache_rd_req_valid) begin
                    line_d = from_cache_rd_req_addr[MEM_AW+1:5];
                    cnt_d  = '0;
`ifdef MEM_BURST_DELAY_EN
                    if (DELAY_CYCLES == 0) begin
                        state_d = BURST;
                    end else begin
                        state_d = DELAY;
                        dly_d   = DLY_LOAD;
                    end
`else
                    state_d = BURST;
`endif
                end
            end

`ifdef MEM_BURST_DELAY_EN
            DELAY: begin
                // Leaving on the 1 -> 0 step puts the first beat exactly
                // DELAY_CYCLES+1 cycles after acceptance.
                dly_d = dly_q - 1'b1;
                if (dly_q == DLY_W'(1)) begin
                    state_d = BURST;
                end
            end
`endif

            BURST: begin
                to_cache_rd_rsp_valid = 1'b1;
                to_cache_rd_rsp_last  = (cnt_q == 3'd7);
                if (from_cache_rd_rsp_ready) begin
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
